// File: rtl/neo_chase_sequencer.sv
// Chasing-head pattern source for the NeoPixel strand controller: loads every channel of every pixel,
// triggers a send, waits for transmission to finish, holds for FRAME_CYCLES, then advances the head.
module neo_chase_sequencer #(
    parameter int NUM_PIXELS   = 5,
    parameter int FRAME_CYCLES = 5_000_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic [1:0] chan_sel,
    input  logic [7:0] level,
    input  logic       ready_to_load,
    input  logic       ready_to_send,
    output logic [2:0] pixel_index,
    output logic [1:0] color_index,
    output logic [7:0] color_level,
    output logic       load_color,
    output logic       send_it,
    output logic [2:0] head_pos,
    output logic       frame_done
);

    localparam int HW = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOAD    = 3'd1;
    localparam logic [2:0] S_SEND    = 3'd2;
    localparam logic [2:0] S_WAIT_TX = 3'd3;
    localparam logic [2:0] S_HOLD    = 3'd4;

    localparam logic [2:0]    LAST_PIX  = 3'(NUM_PIXELS - 1);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(FRAME_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_ONE  = HW'(1);
    localparam logic [HW-1:0] HOLD_ZERO = HW'(0);

    logic [2:0]    state_q, state_d;
    logic [2:0]    head_q, head_d;
    logic [2:0]    pix_q, pix_d;
    logic [1:0]    col_q, col_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [1:0]    sel_q, sel_d;
    logic [7:0]    lvl_q, lvl_d;
    logic          armed_q, armed_d;

    logic [2:0]    tail_s;
    logic          chan_active_s;

    // Next-state and datapath update for the frame sequencer
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        pix_d   = pix_q;
        col_d   = col_q;
        hold_d  = hold_q;
        sel_d   = sel_q;
        lvl_d   = lvl_q;
        armed_d = armed_q;
        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    sel_d   = chan_sel;
                    lvl_d   = level;
                    pix_d   = 3'd0;
                    col_d   = 2'd0;
                    state_d = S_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                if (ready_to_load) begin
                    if (col_q == 2'd2) begin
                        col_d = 2'd0;
                        if (pix_q == LAST_PIX) begin
                            pix_d   = 3'd0;
                            state_d = S_SEND;
                        end else begin
                            pix_d = pix_q + 3'd1;
                        end
                    end else begin
                        col_d = col_q + 2'd1;
                    end
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_SEND: begin
                if (ready_to_send) begin
                    armed_d = 1'b0;
                    state_d = S_WAIT_TX;
                end else begin
                    state_d = S_SEND;
                end
            end
            S_WAIT_TX: begin
                // The first cycle after send_it may still show the controller's stale ready
                if (!armed_q) begin
                    armed_d = 1'b1;
                end else if (ready_to_load) begin
                    hold_d  = HOLD_LOAD;
                    state_d = S_HOLD;
                end else begin
                    state_d = S_WAIT_TX;
                end
            end
            S_HOLD: begin
                if (hold_q == HOLD_ZERO) begin
                    head_d = (head_q == LAST_PIX) ? 3'd0 : head_q + 3'd1;
                    if (enable) begin
                        sel_d   = chan_sel;
                        lvl_d   = level;
                        pix_d   = 3'd0;
                        col_d   = 2'd0;
                        state_d = S_LOAD;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    hold_d = hold_q - HOLD_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and frame registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            head_q  <= 3'd0;
            pix_q   <= 3'd0;
            col_q   <= 2'd0;
            hold_q  <= HOLD_ZERO;
            sel_q   <= 2'd0;
            lvl_q   <= 8'd0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            pix_q   <= pix_d;
            col_q   <= col_d;
            hold_q  <= hold_d;
            sel_q   <= sel_d;
            lvl_q   <= lvl_d;
            armed_q <= armed_d;
        end
    end

    assign tail_s        = (head_q == 3'd0) ? LAST_PIX : head_q - 3'd1;
    assign chan_active_s = (sel_q == 2'b11) || (col_q == sel_q);

    // Value decode for the channel currently addressed; head rule takes priority over tail
    always_comb begin
        if (state_q != S_LOAD) begin
            color_level = 8'd0;
        end else if (chan_active_s && (pix_q == head_q)) begin
            color_level = lvl_q;
        end else if (chan_active_s && (pix_q == tail_s)) begin
            color_level = {1'b0, lvl_q[7:1]};
        end else begin
            color_level = 8'd0;
        end
    end

    assign load_color  = (state_q == S_LOAD) && ready_to_load;
    assign send_it     = (state_q == S_SEND) && ready_to_send;
    assign frame_done  = (state_q == S_WAIT_TX) && armed_q && ready_to_load;
    assign pixel_index = pix_q;
    assign color_index = col_q;
    assign head_pos    = head_q;

endmodule

// File: tb/tb_neo_chase_sequencer.sv
// Bench for neo_chase_sequencer: a frame-level model (strobe index k, modulo head/tail arithmetic)
// checked every cycle, plus literal expectations for selected strobes and head positions.
module tb_neo_chase_sequencer;

    localparam int NP = 5;
    localparam int FC = 8;

    localparam int M_IDLE = 0;
    localparam int M_LOAD = 1;
    localparam int M_SEND = 2;
    localparam int M_TX   = 3;
    localparam int M_HOLD = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic [1:0] chan_sel = 2'd0;
    logic [7:0] level = 8'd0;
    logic       ready_to_load = 1'b1;
    logic       ready_to_send = 1'b1;
    logic [2:0] pixel_index;
    logic [1:0] color_index;
    logic [7:0] color_level;
    logic       load_color;
    logic       send_it;
    logic [2:0] head_pos;
    logic       frame_done;

    int checks = 0;
    int errors = 0;
    bit bp_mode = 1'b0;

    int ph = M_IDLE;
    int k = 0;
    int m_head = 0;
    int hc = 0;
    bit armed = 1'b0;
    int m_sel = 0;
    int m_lvl = 0;
    int nf = 0;
    int done_cnt = 0;
    int send_cnt = 0;
    int total_strobes = 0;
    int obs_cnt[16];
    int obs_lvl[16][15];
    int obs_head[16];
    bit el, es, ed;

    neo_chase_sequencer #(.NUM_PIXELS(NP), .FRAME_CYCLES(FC)) dut (
        .clock(clock), .reset(reset), .enable(enable), .chan_sel(chan_sel), .level(level),
        .ready_to_load(ready_to_load), .ready_to_send(ready_to_send),
        .pixel_index(pixel_index), .color_index(color_index), .color_level(color_level),
        .load_color(load_color), .send_it(send_it), .head_pos(head_pos), .frame_done(frame_done)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int exp_level(input int p, input int c, input int h, input int sel, input int lv);
        int  tail;
        bit  act;
        tail = (h + NP - 1) % NP;
        act  = (sel == 3) || (c == sel);
        if (act && p == h) return lv;
        if (act && p == tail) return lv / 2;
        return 0;
    endfunction

    // which: 0 = frame_done count, 1 = send count, 2 = strobes observed in frame f
    task automatic wait_for(input int which, input int f, input int n, input string name);
        int cur;
        for (int i = 0; i < 4000; i++) begin
            cur = (which == 0) ? done_cnt : (which == 1) ? send_cnt : obs_cnt[f];
            if (cur >= n) break;
            @(negedge clock);
            #1;
        end
        cur = (which == 0) ? done_cnt : (which == 1) ? send_cnt : obs_cnt[f];
        chk(name, int'(cur >= n), 1);
    endtask

    // ready_to_load source: always ready, or toggling every cycle under backpressure
    initial begin
        forever begin
            @(posedge clock);
            #1;
            ready_to_load = bp_mode ? ~ready_to_load : 1'b1;
        end
    end

    // Per-cycle compare against the frame model, sampled on the falling edge
    initial begin
        forever begin
            @(negedge clock);
            if (reset) begin
                chk("rst_load", load_color, 0);
                chk("rst_send", send_it, 0);
                chk("rst_done", frame_done, 0);
                chk("rst_head", head_pos, 0);
                chk("rst_pix", pixel_index, 0);
                chk("rst_col", color_index, 0);
                chk("rst_lvl", color_level, 0);
                ph = M_IDLE; m_head = 0; armed = 1'b0; k = 0;
            end else begin
                el = (ph == M_LOAD) && ready_to_load;
                es = (ph == M_SEND) && ready_to_send;
                ed = (ph == M_TX) && armed && ready_to_load;
                chk("load_color", load_color, el);
                chk("send_it", send_it, es);
                chk("frame_done", frame_done, ed);
                chk("head_pos", head_pos, m_head);
                if (load_color) begin
                    total_strobes++;
                    if (nf > 0 && nf <= 16) obs_cnt[nf-1]++;
                end
                if (el && load_color && nf > 0 && nf <= 16) begin
                    chk("pixel_index", pixel_index, k / 3);
                    chk("color_index", color_index, k % 3);
                    chk("color_level", color_level, exp_level(k / 3, k % 3, m_head, m_sel, m_lvl));
                    obs_lvl[nf-1][k] = color_level;
                    if (k == 0) obs_head[nf-1] = head_pos;
                end
                if (send_it) send_cnt++;
                if (frame_done) done_cnt++;
                case (ph)
                    M_IDLE: if (enable) begin m_sel = chan_sel; m_lvl = level; k = 0; nf++; ph = M_LOAD; end
                    M_LOAD: if (ready_to_load) begin k++; if (k == NP * 3) ph = M_SEND; end
                    M_SEND: if (ready_to_send) begin armed = 1'b0; ph = M_TX; end
                    M_TX: begin
                        if (!armed) armed = 1'b1;
                        else if (ready_to_load) begin hc = FC; ph = M_HOLD; end
                    end
                    M_HOLD: begin
                        hc--;
                        if (hc == 0) begin
                            m_head = (m_head + 1) % NP;
                            if (enable) begin m_sel = chan_sel; m_lvl = level; k = 0; nf++; ph = M_LOAD; end
                            else ph = M_IDLE;
                        end
                    end
                    default: ph = M_IDLE;
                endcase
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired t=%0t", $time);
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int snap;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        #1;
        chk("post_rst_head", head_pos, 0);
        chk("post_rst_load", load_color, 0);

        // Five frames plus the wrap back to head 0, single red channel
        @(posedge clock); #1;
        enable = 1'b1; chan_sel = 2'd0; level = 8'hC8;
        wait_for(0, 0, 5, "timeout_done5");
        @(posedge clock); #1;
        bp_mode = 1'b1;
        wait_for(0, 0, 6, "timeout_done6");
        @(posedge clock); #1;
        bp_mode = 1'b0; chan_sel = 2'd3; level = 8'h0F;
        chk("f0_cnt", obs_cnt[0], 15);
        chk("f0_head_R", obs_lvl[0][0], 8'hC8);
        chk("f0_tail_R", obs_lvl[0][12], 8'h64);
        chk("f0_p1_R", obs_lvl[0][3], 0);
        chk("f0_p0_G", obs_lvl[0][1], 0);
        chk("f1_head_R", obs_lvl[1][3], 8'hC8);
        chk("f1_tail_R", obs_lvl[1][0], 8'h64);
        for (int f = 0; f < 6; f++) chk($sformatf("head_seq%0d", f), obs_head[f], f % NP);
        chk("bp_cnt", obs_cnt[5], 15);
        chk("bp_head_R", obs_lvl[5][0], 8'hC8);
        chk("bp_tail_R", obs_lvl[5][12], 8'h64);

        // All channels lit with a low level, then a level change mid-frame
        wait_for(0, 0, 7, "timeout_done7");
        @(posedge clock); #1;
        chan_sel = 2'd1; level = 8'hC8;
        for (int i = 0; i < 3; i++) chk($sformatf("w_tail%0d", i), obs_lvl[6][i], 8'h07);
        for (int i = 3; i < 6; i++) chk($sformatf("w_head%0d", i), obs_lvl[6][i], 8'h0F);
        chk("w_p2_R", obs_lvl[6][6], 0);
        wait_for(2, 7, 2, "timeout_f7_strobes");
        @(posedge clock); #1;
        level = 8'hFF;
        wait_for(1, 0, 8, "timeout_send8");
        @(posedge clock); #1;
        enable = 1'b0;
        wait_for(0, 0, 8, "timeout_done8");
        snap = total_strobes;
        repeat (20) @(negedge clock);
        #1;
        chk("f7_head_G", obs_lvl[7][7], 8'hC8);
        chk("f7_tail_G", obs_lvl[7][4], 8'h64);
        chk("f7_p2_R", obs_lvl[7][6], 0);
        chk("idle_head", head_pos, 3);
        chk("idle_no_strobes", total_strobes, snap);
        chk("idle_frames", nf, 8);

        // Reset in the middle of pixel 2, then a fresh frame
        @(posedge clock); #1;
        level = 8'hC8; chan_sel = 2'd0; enable = 1'b1;
        wait_for(2, 8, 6, "timeout_f8_strobes");
        @(posedge clock); #1;
        chk("pix_before_rst", pixel_index, 2);
        reset = 1'b1;
        #1;
        chk("abort_load", load_color, 0);
        chk("abort_head", head_pos, 0);
        chk("abort_lvl", color_level, 0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        wait_for(0, 0, 9, "timeout_done9");
        chk("f9_cnt", obs_cnt[9], 15);
        chk("f9_start_head", obs_head[9], 0);
        chk("f9_head_R", obs_lvl[9][0], 8'hC8);
        chk("f9_tail_R", obs_lvl[9][12], 8'h64);
        repeat (3) @(negedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
